lcd_rx: RTL and testbench

LCD_RX -- requirements
Module: lcd_rx

---
 rtl/lcd_pkg.sv | 47 ++++
 rtl/lcd_rx_if.sv | 10 +
 rtl/lcd_strobe_sync.sv | 37 +++
 rtl/lcd_rx.sv | 150 +++++++++++++++
 tb/tb_lcd_rx.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD receiver: instruction bit
// positions, blank code, FSM encoding and DDRAM address helpers.
package lcd_pkg;

    localparam int unsigned BIT_DDRAM = 7;
    localparam int unsigned BIT_CGRAM = 6;
    localparam int unsigned BIT_FUNC  = 5;
    localparam int unsigned BIT_SHIFT = 4;
    localparam int unsigned BIT_DISP  = 3;
    localparam int unsigned BIT_ENTRY = 2;
    localparam int unsigned BIT_HOME  = 1;
    localparam int unsigned BIT_CLEAR = 0;

    localparam logic [7:0]  BLANK     = 8'h20;
    localparam int unsigned NUM_CELLS = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CLEAR = 2'd2
    } lcd_state_e;

    typedef struct packed {
        logic       rs;
        logic       rw;
        logic [7:0] data;
    } lcd_cmd_t;

    // Only 0x00-0x0F (line 1) and 0x40-0x4F (line 2) are backed by cells.
    function automatic logic ac_valid(input logic [6:0] a);
        return a[5:4] == 2'b00;
    endfunction

    function automatic logic [4:0] ac_cell(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a[3:0] == 4'hF) return a[6] ? 7'h00 : 7'h40;
            return a + 7'd1;
        end
        if (a[3:0] == 4'h0) return a[6] ? 7'h0F : 7'h4F;
        return a - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_rx_if.sv
// Parallel LCD bus as driven by an external LCD controller.
interface lcd_rx_if;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;

    modport master (output LCD_E, LCD_RS, LCD_RW, LCD_DATA);
    modport slave  (input  LCD_E, LCD_RS, LCD_RW, LCD_DATA);
endinterface

// File: rtl/lcd_strobe_sync.sv
// Two-flop synchronizers for the LCD bus plus falling-edge detect on E.
module lcd_strobe_sync
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       e_in,
    input  logic       rs_in,
    input  logic       rw_in,
    input  logic [7:0] data_in,
    output logic       stb,
    output lcd_cmd_t   cmd
);

    // e_sh[1:0] is the synchronizer, e_sh[2] the previous synchronized E.
    logic [2:0] e_sh;
    lcd_cmd_t   c_s1, c_s2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            e_sh <= '0;
            c_s1 <= '0;
            c_s2 <= '0;
            cmd  <= '0;
        end else begin
            e_sh <= {e_sh[1:0], e_in};
            c_s1 <= {rs_in, rw_in, data_in};
            c_s2 <= c_s1;
            cmd  <= c_s2;
        end
    end

    // cmd lags c_s2 by one cycle, matching e_sh[2], so on the falling edge it
    // holds the bus values of the last cycle E was seen high.
    assign stb = e_sh[2] & ~e_sh[1];

endmodule

// File: rtl/lcd_rx.sv
// LCD controller emulator: decodes strobes from an LCD driver into a 2x16
// character DDRAM, cursor, display-on bit and emulated busy flag.
module lcd_rx
    import lcd_pkg::*;
#(
    parameter int BUSY_CYCLES = 40,
    parameter int CLR_CYCLES  = 1600
) (
    input  logic        clk,
    input  logic        resetn,
    lcd_rx_if.slave     lcd,
    input  logic [4:0]  rd_idx,
    output logic [7:0]  rd_data,
    output logic [6:0]  cursor,
    output logic        disp_on,
    output logic        busy,
    output logic        wr_pulse,
    output logic        err
);

    localparam int CNT_MAX = (CLR_CYCLES > BUSY_CYCLES) ? CLR_CYCLES : BUSY_CYCLES;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    logic       stb;
    lcd_cmd_t   cmd;

    lcd_state_e state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic       id, id_nxt, disp_nxt, wr_nxt, err_nxt;
    logic [6:0] ac_nxt;
    logic       mem_we;
    logic [4:0] mem_wa;
    logic [7:0] mem_wd;
    logic [NUM_CELLS-1:0][7:0] mem;

    lcd_strobe_sync u_sync (
        .clk     (clk),
        .resetn  (resetn),
        .e_in    (lcd.LCD_E),
        .rs_in   (lcd.LCD_RS),
        .rw_in   (lcd.LCD_RW),
        .data_in (lcd.LCD_DATA),
        .stb     (stb),
        .cmd     (cmd)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ac_nxt    = cursor;
        id_nxt    = id;
        disp_nxt  = disp_on;
        wr_nxt    = 1'b0;
        err_nxt   = 1'b0;
        mem_we    = 1'b0;
        mem_wa    = ac_cell(cursor);
        mem_wd    = cmd.data;

        case (state)
            ST_IDLE: begin
                if (stb && !cmd.rw) begin
                    if (cmd.rs) begin
                        mem_we    = 1'b1;
                        ac_nxt    = ac_step(cursor, id);
                        wr_nxt    = 1'b1;
                        state_nxt = ST_EXEC;
                    end else if (cmd.data[BIT_DDRAM]) begin
                        if (ac_valid(cmd.data[6:0])) begin
                            ac_nxt    = cmd.data[6:0];
                            state_nxt = ST_EXEC;
                        end else begin
                            err_nxt   = 1'b1;
                        end
                    end else if (cmd.data[BIT_CGRAM] || cmd.data[BIT_FUNC] || cmd.data[BIT_SHIFT]) begin
                        state_nxt = ST_EXEC;
                    end else if (cmd.data[BIT_DISP]) begin
                        disp_nxt  = cmd.data[2];
                        state_nxt = ST_EXEC;
                    end else if (cmd.data[BIT_ENTRY]) begin
                        id_nxt    = cmd.data[1];
                        state_nxt = ST_EXEC;
                    end else if (cmd.data[BIT_HOME]) begin
                        ac_nxt    = 7'h00;
                        state_nxt = ST_EXEC;
                    end else if (cmd.data[BIT_CLEAR]) begin
                        state_nxt = ST_CLEAR;
                    end else begin
                        err_nxt   = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                if (stb && !cmd.rw) err_nxt = 1'b1;
                if (cnt == CW'(BUSY_CYCLES - 1)) state_nxt = ST_IDLE;
            end
            ST_CLEAR: begin
                if (stb && !cmd.rw) err_nxt = 1'b1;
                // First NUM_CELLS cycles blank one cell each, then home the cursor.
                if (cnt < CW'(NUM_CELLS)) begin
                    mem_we = 1'b1;
                    mem_wa = cnt[4:0];
                    mem_wd = BLANK;
                end
                if (cnt == CW'(NUM_CELLS)) begin
                    ac_nxt = 7'h00;
                    id_nxt = 1'b1;
                end
                if (cnt == CW'(CLR_CYCLES - 1)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        cnt_nxt = (state_nxt == state && state != ST_IDLE) ? cnt + CW'(1) : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            cursor   <= 7'h00;
            id       <= 1'b1;
            disp_on  <= 1'b0;
            wr_pulse <= 1'b0;
            err      <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            cursor   <= ac_nxt;
            id       <= id_nxt;
            disp_on  <= disp_nxt;
            wr_pulse <= wr_nxt;
            err      <= err_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem     <= {NUM_CELLS{BLANK}};
            rd_data <= BLANK;
        end else begin
            if (mem_we) mem[mem_wa] <= mem_wd;
            rd_data <= mem[rd_idx];
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_lcd_rx.sv
// Directed bench for lcd_rx: queued expectations for wr_pulse, err and
// DDRAM reads are checked by a monitor; busy lengths and state checked inline.
module tb_lcd_rx;

    localparam int BUSY_C = 20;
    localparam int CLR_C  = 40;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [4:0] rd_idx = '0;
    logic [7:0] rd_data;
    logic [6:0] cursor;
    logic       disp_on, busy, wr_pulse, err;

    lcd_rx_if bus ();

    lcd_rx #(.BUSY_CYCLES(BUSY_C), .CLR_CYCLES(CLR_C)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .lcd      (bus),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data),
        .cursor   (cursor),
        .disp_on  (disp_on),
        .busy     (busy),
        .wr_pulse (wr_pulse),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_q[$];
    int err_q[$];
    int rd_q[$];
    logic rd_req = 1'b0;
    logic rd_req_q = 1'b0;

    always @(posedge clk) rd_req_q <= rd_req;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every DUT pulse or read response consumes one expectation.
    always @(negedge clk) begin
        if (wr_pulse) begin
            if (wr_q.size() == 0) chk("wr_pulse_unexpected", int'(wr_pulse), 0);
            else                  chk("wr_cursor", int'(cursor), wr_q.pop_front());
        end
        if (err) begin
            if (err_q.size() == 0) chk("err_unexpected", int'(err), 0);
            else                   chk("err_cursor", int'(cursor), err_q.pop_front());
        end
        if (rd_req_q && rd_q.size() != 0) chk("rd_data", int'(rd_data), rd_q.pop_front());
    end

    task automatic pulse_e(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        bus.LCD_RS   = rs;
        bus.LCD_RW   = rw;
        bus.LCD_DATA = d;
        bus.LCD_E    = 1'b1;
        repeat (4) @(negedge clk);
        bus.LCD_E    = 1'b0;
    endtask

    // Counts busy cycles following a strobe; returns once busy has dropped.
    task automatic settle(output int n);
        n = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (busy) n++;
            else if (n > 0 || i >= 8) return;
        end
        chk("busy_timeout", int'(busy), 0);
    endtask

    task automatic send(input logic rs, input logic [7:0] d);
        int n;
        pulse_e(rs, 1'b0, d);
        settle(n);
    endtask

    task automatic rd(input int idx, input int exp);
        @(negedge clk);
        rd_idx = 5'(idx);
        rd_req = 1'b1;
        rd_q.push_back(exp);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    function automatic int fill_ac(input int k);
        if (k < 15) return k + 1;
        if (k < 31) return 'h40 + (k - 15);
        return 0;
    endfunction

    initial begin
        int n;
        bus.LCD_E = 1'b0; bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0; bus.LCD_DATA = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cursor", int'(cursor), 0);
        chk("rst_disp_on", int'(disp_on), 0);
        chk("rst_wr_pulse", int'(wr_pulse), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_rd_data", int'(rd_data), 'h20);
        resetn = 1'b1;

        // Basic address set and two data writes.
        send(0, 8'h80);
        wr_q.push_back('h01); send(1, 8'h41);
        wr_q.push_back('h02); send(1, 8'h42);
        rd(0, 'h41); rd(1, 'h42);
        chk("cursor_t1", int'(cursor), 'h02);

        // Increment across line boundary 0x0F -> 0x40.
        send(0, 8'h8F);
        wr_q.push_back('h40); send(1, 8'h58);
        wr_q.push_back('h41); send(1, 8'h59);
        rd(15, 'h58); rd(16, 'h59);
        chk("cursor_t2", int'(cursor), 'h41);

        // Decrement mode: 0x40 -> 0x0F and 0x00 -> 0x4F.
        send(0, 8'h04);
        send(0, 8'hC0);
        wr_q.push_back('h0F); send(1, 8'h5A);
        rd(16, 'h5A);
        chk("cursor_t3", int'(cursor), 'h0F);
        send(0, 8'h80);
        wr_q.push_back('h4F); send(1, 8'h33);
        rd(0, 'h33);
        send(0, 8'h06);
        send(0, 8'hCF);
        wr_q.push_back('h00); send(1, 8'h34);
        rd(31, 'h34);

        // Fill every cell, then clear with decrement mode selected.
        send(0, 8'h80);
        for (int k = 0; k < 32; k++) begin
            wr_q.push_back(fill_ac(k));
            send(1, 8'h30);
        end
        rd(0, 'h30); rd(15, 'h30); rd(16, 'h30); rd(31, 'h30);
        send(0, 8'h04);
        send(0, 8'h85);
        pulse_e(0, 0, 8'h01);
        settle(n);
        chk("clear_busy_len", n, CLR_C);
        for (int i = 0; i < 32; i++) rd(i, 'h20);
        chk("cursor_after_clear", int'(cursor), 0);
        wr_q.push_back('h01); send(1, 8'h61);
        rd(0, 'h61);

        // Error cases: write while busy, out-of-range address, 0x00, and a read strobe.
        pulse_e(0, 0, 8'h8A);
        repeat (6) @(negedge clk);
        chk("busy_during_exec", int'(busy), 1);
        err_q.push_back('h0A);
        pulse_e(1, 0, 8'h77);
        settle(n);
        chk("cursor_after_busy_drop", int'(cursor), 'h0A);
        rd(10, 'h20);
        err_q.push_back('h0A); send(0, 8'h90);
        chk("cursor_after_bad_addr", int'(cursor), 'h0A);
        chk("busy_after_bad_addr", int'(busy), 0);
        err_q.push_back('h0A); send(0, 8'h00);
        chk("busy_after_zero", int'(busy), 0);
        pulse_e(0, 1, 8'h01);
        settle(n);
        chk("read_strobe_busy", n, 0);
        chk("cursor_after_read_strobe", int'(cursor), 'h0A);

        // Display on, then reset in the middle of EXEC.
        pulse_e(0, 0, 8'h0C);
        settle(n);
        chk("exec_busy_len", n, BUSY_C);
        chk("disp_on_set", int'(disp_on), 1);
        wr_q.push_back('h0B); send(1, 8'h55);
        rd(10, 'h55);
        pulse_e(0, 0, 8'h0C);
        repeat (6) @(negedge clk);
        chk("busy_before_reset", int'(busy), 1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_disp_on", int'(disp_on), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_cursor", int'(cursor), 0);
        chk("mid_rst_rd_data", int'(rd_data), 'h20);
        @(negedge clk);
        resetn = 1'b1;
        rd(10, 'h20); rd(0, 'h20); rd(16, 'h20);

        repeat (10) @(negedge clk);
        chk("wr_q_left", wr_q.size(), 0);
        chk("err_q_left", err_q.size(), 0);
        chk("rd_q_left", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
